cic_decimator: RTL and testbench



---
 rtl/cic_decimator_pkg.sv | 13 +
 rtl/cic_integrator.sv | 22 ++
 rtl/cic_decimator.sv | 117 +++++++++++
 tb/tb_cic_decimator.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cic_decimator_pkg.sv
// cic_decimator_pkg: shared CIC sizing, adctl/features register fields and helpers.
package cic_decimator_pkg;
  localparam int CIC_STAGES = 3;
  localparam int CIC_RATE_LOG2_MAX = 4;
  localparam int ADCTL_RATE_LSB = 4;
  localparam int ADCTL_RATE_MSB = 6;
  localparam int FEATURES_CIC_BIT = 5;
  localparam logic [31:0] FEATURES_CIC_MASK = 32'd1 << FEATURES_CIC_BIT;
  typedef logic [2:0] rate_t;
  function automatic rate_t clamp_rate(input rate_t r, input int max_k);
    return (int'(r) > max_k) ? rate_t'(max_k) : r;
  endfunction
endpackage

// File: rtl/cic_integrator.sv
// cic_integrator: one W-bit modulo accumulator stage with enable and synchronous clear.
module cic_integrator #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] add_i,
  output logic [W-1:0] acc_o
);
  logic [W-1:0] acc_q, acc_d;

  always_comb acc_d = clr_i ? '0 : en_i ? acc_q + add_i : acc_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) acc_q <= '0;
    else acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator, R = 2^k chosen at runtime, gain exactly 1.
// A rate change or reset clears all history and hides the first STAGES outputs.
module cic_decimator
  import cic_decimator_pkg::*;
#(
  parameter int BITS          = 12,
  parameter int STAGES        = CIC_STAGES,
  parameter int RATE_LOG2_MAX = CIC_RATE_LOG2_MAX,
  parameter bit OFFSET_BIN    = 1'b1
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [2:0]      rate_log2,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  output logic [BITS-1:0] out_data
);
  localparam int W = BITS + STAGES * RATE_LOG2_MAX;
  localparam int CW = RATE_LOG2_MAX;
  localparam int SW = $clog2(STAGES + 1);
  localparam logic [BITS-1:0] MSB = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] FLIP = OFFSET_BIN ? MSB : '0;

  rate_t rate_q, rate_d, k_q, k_d;
  logic load_q, clr, take, last;
  logic stb_q, stb_d, out_valid_q, out_valid_d;
  logic [CW-1:0] cnt_q, cnt_d, mask;
  logic [SW-1:0] sup_q, sup_d;
  logic [BITS-1:0] xs, y, out_data_q, out_data_d;
  logic [W-1:0] xin, comb;
  logic [7:0] shamt;
  logic [STAGES-1:0][W-1:0] acc, prev_q, prev_d;

  assign xs = in_data ^ FLIP;
  assign xin = {{(W-BITS){xs[BITS-1]}}, xs};

  // load_q forces one clearing cycle after reset so k is taken from rate_log2
  assign rate_d = clamp_rate(rate_log2, RATE_LOG2_MAX);
  assign clr = load_q || (rate_q != k_q);
  assign take = in_valid && !clr;
  assign mask = ~({CW{1'b1}} << k_q);
  assign last = (cnt_q == mask);
  assign shamt = 8'(k_q) * 8'(STAGES);

  for (genvar g = 0; g < STAGES; g++) begin : g_int
    if (g == 0) begin : g_first
      cic_integrator #(.W(W)) u_int (
        .clk(clk),
        .nreset(nreset),
        .en_i(take),
        .clr_i(clr),
        .add_i(xin),
        .acc_o(acc[g])
      );
    end else begin : g_next
      cic_integrator #(.W(W)) u_int (
        .clk(clk),
        .nreset(nreset),
        .en_i(take),
        .clr_i(clr),
        .add_i(acc[g-1]),
        .acc_o(acc[g])
      );
    end
  end

  always_comb begin
    logic [W-1:0] x;
    prev_d = prev_q;
    x = acc[STAGES-1];
    for (int i = 0; i < STAGES; i++) begin
      prev_d[i] = clr ? '0 : stb_q ? x : prev_q[i];
      x = x - prev_q[i];
    end
    comb = x;
  end

  // R^N / 2^(N*k) == 1, so the arithmetic shift restores input scale exactly
  assign y = BITS'($signed(comb) >>> shamt) ^ FLIP;

  always_comb begin
    k_d = load_q ? rate_d : rate_q;
    cnt_d = clr ? '0 : take ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    stb_d = take && last;
    sup_d = clr ? SW'(STAGES) : (stb_q && sup_q != '0) ? sup_q - SW'(1) : sup_q;
    out_valid_d = stb_q && !clr && (sup_q == '0);
    out_data_d = out_valid_d ? y : out_data_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rate_q <= '0;
      k_q <= '0;
      load_q <= 1'b1;
      cnt_q <= '0;
      stb_q <= 1'b0;
      sup_q <= SW'(STAGES);
      prev_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      rate_q <= rate_d;
      k_q <= k_d;
      load_q <= 1'b0;
      cnt_q <= cnt_d;
      stb_q <= stb_d;
      sup_q <= sup_d;
      prev_q <= prev_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: directed bench with hand-derived CIC responses (DC, ramp, step,
// wrap-around, clamp, rate change and mid-group reset).
module tb_cic_decimator;
  logic clk = 1'b0;
  logic nreset;
  logic [2:0] rate_log2;
  logic in_valid;
  logic [11:0] in_data;
  logic out_valid;
  logic [11:0] out_data;
  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];

  cic_decimator dut (
    .clk(clk),
    .nreset(nreset),
    .rate_log2(rate_log2),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_dc(input logic [11:0] v, input int cnt);
    repeat (cnt) exp_q.push_back(v);
  endtask

  task automatic set_rate(input logic [2:0] r);
    rate_log2 = r;
    repeat (4) begin
      @(negedge clk);
      chk("idle_valid", 12'(out_valid), 12'h000);
    end
  endtask

  // back-to-back samples; sample i = (i < step_at ? x0 : x1) + inc*i
  // out_valid is expected exactly one cycle per group, 2 clk after its last sample
  task automatic burst(input logic [11:0] x0, input logic [11:0] x1, input int step_at,
                       input int inc, input int k, input int n);
    int r = 1 << k;
    int j;
    logic ev;
    logic [11:0] e;
    for (int i = 0; i < n + 3; i++) begin
      in_valid = (i < n);
      in_data = ((i < step_at) ? x0 : x1) + 12'(inc * i);
      @(negedge clk);
      j = i - 1;
      ev = (j >= 0) && (j < n) && ((j % r) == r - 1) && (j / r >= 3);
      chk("out_valid", 12'(out_valid), 12'(ev));
      if (ev) begin
        e = 12'h000;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("out_data", out_data, e);
      end
    end
    in_valid = 1'b0;
    chk("outputs_left", 12'(exp_q.size()), 12'h000);
  endtask

  initial begin
    nreset = 1'b0;
    rate_log2 = 3'd2;
    in_valid = 1'b0;
    in_data = 12'h800;
    repeat (3) @(negedge clk);
    chk("rst_valid", 12'(out_valid), 12'h000);
    chk("rst_data", out_data, 12'h000);
    nreset = 1'b1;
    repeat (3) @(negedge clk);

    push_dc(12'h864, 3);
    burst(12'h864, 12'h864, 24, 0, 2, 24);

    set_rate(3'd0);
    for (int j = 3; j < 256; j++) exp_q.push_back(12'(12'h800 + j - 2));
    burst(12'h800, 12'h800, 256, 1, 0, 256);

    set_rate(3'd4);
    push_dc(12'hFFF, 72);
    burst(12'hFFF, 12'hFFF, 1200, 0, 4, 1200);

    nreset = 1'b0;
    rate_log2 = 3'd7;
    @(negedge clk);
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    push_dc(12'h000, 72);
    burst(12'h000, 12'h000, 1200, 0, 4, 1200);

    set_rate(3'd1);
    push_dc(12'h800, 3);
    exp_q.push_back(12'h990);
    push_dc(12'hB20, 3);
    burst(12'h800, 12'hB20, 10, 0, 1, 20);

    set_rate(3'd2);
    push_dc(12'h3A0, 1);
    burst(12'h3A0, 12'h3A0, 18, 0, 2, 18);
    rate_log2 = 3'd3;
    @(negedge clk);
    chk("chg_valid0", 12'(out_valid), 12'h000);
    in_valid = 1'b1;
    in_data = 12'h3A0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("chg_valid1", 12'(out_valid), 12'h000);
    push_dc(12'h3A0, 2);
    burst(12'h3A0, 12'h3A0, 40, 0, 3, 40);

    set_rate(3'd2);
    burst(12'hC00, 12'hC00, 2, 0, 2, 2);
    nreset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_valid", 12'(out_valid), 12'h000);
      chk("midrst_data", out_data, 12'h000);
    end
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    push_dc(12'hC00, 2);
    burst(12'hC00, 12'hC00, 20, 0, 2, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
